sram_port_arbiter: RTL

Two-requester controller for the single-port 4096x32 byte-masked data SRAM macro. It arbitrates round-robin between a core port (0) and a DMA/debug port (1), drives the macro's enable/wmode/addr/mask/wdata, and routes the one-cycle-latency read data back to the issuing port. An optional post-reset zero-fill engine clears the whole array before either port is served. It sits between the tile's memory-side logic and the SRAM macro instance.

---
 rtl/sram_ctrl_pkg.sv | 21 ++
 rtl/rr_arb2.sv | 33 +++
 rtl/sram_port_arbiter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared constants and types for the data-SRAM port controller.
package sram_ctrl_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;
    localparam int MASK_W = DATA_W / 8;
    localparam int DEPTH  = 2 ** ADDR_W;

    typedef enum logic {
        INIT,
        RUN
    } state_e;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [MASK_W-1:0] mask;
        logic [DATA_W-1:0] wdata;
    } req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; last_q names the port granted most recently.
module rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    logic last_q;
    logic last_d;

    always_comb begin
        gnt_o  = req_i;
        last_d = last_q;
        if (req_i == 2'b11) begin
            gnt_o = last_q ? 2'b01 : 2'b10;
        end
        if (gnt_o[0]) begin
            last_d = 1'b0;
        end else if (gnt_o[1]) begin
            last_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Two-port round-robin front end for the 4096x32 byte-masked data SRAM.
// SRAM_INIT_CLEAR_EN adds a post-reset zero-fill of the whole array.
module sram_port_arbiter
    import sram_ctrl_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [MASK_W-1:0] req0_mask,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [MASK_W-1:0] req1_mask,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              resp0_valid,
    output logic [DATA_W-1:0] resp0_rdata,
    output logic              resp1_valid,
    output logic [DATA_W-1:0] resp1_rdata,
    output logic              sram_en,
    output logic              sram_wmode,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [MASK_W-1:0] sram_wmask,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              init_done
);

    state_e     state_q;
    state_e     state_d;
    logic       rd_pend_q;
    logic       rd_pend_d;
    logic       rd_port_q;
    logic       rd_port_d;
    logic       run;
    logic [1:0] valid;
    logic [1:0] gnt;
    req_t       req0;
    req_t       req1;
    req_t       sel;

`ifdef SRAM_INIT_CLEAR_EN
    logic [ADDR_W-1:0] clr_addr_q;
    logic [ADDR_W-1:0] clr_addr_d;
    logic              clr_last;

    assign clr_last = (clr_addr_q == ADDR_W'(DEPTH - 1));
`endif

    assign req0 = '{write: req0_write, addr: req0_addr,
                    mask: req0_mask, wdata: req0_wdata};
    assign req1 = '{write: req1_write, addr: req1_addr,
                    mask: req1_mask, wdata: req1_wdata};

    // Gating on reset keeps every output at its reset value while held.
    assign run   = (state_q == RUN) && !reset;
    assign valid = {req1_valid, req0_valid} & {2{run}};

    rr_arb2 u_arb (
        .clk_i (clock),
        .rst_i (reset),
        .req_i (valid),
        .gnt_o (gnt)
    );

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];
    assign sel        = gnt[1] ? req1 : req0;
    assign init_done  = run;

    assign resp0_valid = rd_pend_q && !rd_port_q;
    assign resp1_valid = rd_pend_q && rd_port_q;
    assign resp0_rdata = sram_rdata;
    assign resp1_rdata = sram_rdata;

    always_comb begin
        state_d    = state_q;
        rd_pend_d  = 1'b0;
        rd_port_d  = rd_port_q;
        sram_en    = 1'b0;
        sram_wmode = 1'b0;
        sram_addr  = '0;
        sram_wmask = '0;
        sram_wdata = '0;
`ifdef SRAM_INIT_CLEAR_EN
        clr_addr_d = clr_addr_q;
`endif
        unique case (state_q)
            INIT: begin
`ifdef SRAM_INIT_CLEAR_EN
                if (!reset) begin
                    sram_en    = 1'b1;
                    sram_wmode = 1'b1;
                    sram_addr  = clr_addr_q;
                    sram_wmask = '1;
                    if (clr_last) begin
                        state_d = RUN;
                    end else begin
                        clr_addr_d = clr_addr_q + 1'b1;
                    end
                end
`else
                state_d = RUN;
`endif
            end
            RUN: begin
                if (|gnt) begin
                    sram_en    = 1'b1;
                    sram_wmode = sel.write;
                    sram_addr  = sel.addr;
                    if (sel.write) begin
                        sram_wmask = sel.mask;
                        sram_wdata = sel.wdata;
                    end else begin
                        rd_pend_d = 1'b1;
                        rd_port_d = gnt[1];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= INIT;
            rd_pend_q <= 1'b0;
            rd_port_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_pend_q <= rd_pend_d;
            rd_port_q <= rd_port_d;
        end
    end

`ifdef SRAM_INIT_CLEAR_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            clr_addr_q <= '0;
        end else begin
            clr_addr_q <= clr_addr_d;
        end
    end
`endif

endmodule
